adsr_voice_sched: RTL and testbench



---
 rtl/adsr_voice_sched_if.sv | 44 ++++
 rtl/adsr_voice_sched.sv | 195 +++++++++++++++++++
 tb/tb_adsr_voice_sched.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adsr_voice_sched_if.sv
// Bundle of the event, datapath and mixer-stream signals around the ADSR
// voice scheduler. Signal names keep their direction prefixes as seen from
// the scheduler; the slave modport is the scheduler side.
interface adsr_voice_sched_if #(
  parameter int NUM_VOICES = 16,
  parameter int VIDX_W     = 4
);
  logic                  i_tick;
  logic                  i_ev_valid;
  logic                  o_ev_ready;
  logic                  i_ev_on;
  logic [VIDX_W-1:0]     i_ev_voice;
  logic [3:0]            i_ev_channel;
  logic [NUM_VOICES-1:0] i_drum_busy;
  logic [2:0]            o_adsr_state;
  logic [17:0]           o_adsr_volume;
  logic                  o_adsr_note_pressed;
  logic                  o_adsr_note_released;
  logic [3:0]            o_adsr_channel;
  logic                  o_adsr_fifo_empty;
  logic [2:0]            i_adsr_state;
  logic [17:0]           i_adsr_volume;
  logic                  o_vol_valid;
  logic [VIDX_W-1:0]     o_vol_voice;
  logic [17:0]           o_vol_value;
  logic                  o_busy;
  logic                  o_overrun;

  modport slave (
    input  i_tick, i_ev_valid, i_ev_on, i_ev_voice, i_ev_channel, i_drum_busy,
           i_adsr_state, i_adsr_volume,
    output o_ev_ready, o_adsr_state, o_adsr_volume, o_adsr_note_pressed,
           o_adsr_note_released, o_adsr_channel, o_adsr_fifo_empty,
           o_vol_valid, o_vol_voice, o_vol_value, o_busy, o_overrun
  );

  modport master (
    output i_tick, i_ev_valid, i_ev_on, i_ev_voice, i_ev_channel, i_drum_busy,
           i_adsr_state, i_adsr_volume,
    input  o_ev_ready, o_adsr_state, o_adsr_volume, o_adsr_note_pressed,
           o_adsr_note_released, o_adsr_channel, o_adsr_fifo_empty,
           o_vol_valid, o_vol_voice, o_vol_value, o_busy, o_overrun
  );
endinterface

// File: rtl/adsr_voice_sched.sv
// ADSR voice scheduler: time-multiplexes one shared combinational ADSR update
// datapath across NUM_VOICES voices. Each sample tick sweeps every voice
// through READ (present registers) and WRITE (capture result, strobe mixer).
// Optional build macro ADSR_SKIP_BLANK_EN: blank voices with no pending
// note-on bypass the datapath in a single READ cycle and report volume 0.
module adsr_voice_sched #(
  parameter int NUM_VOICES = 16,
  parameter int VIDX_W     = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  adsr_voice_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} fsm_e;

  localparam logic [2:0]        ST_BLANK = 3'd0;
  localparam logic [VIDX_W-1:0] LAST     = VIDX_W'(NUM_VOICES - 1);

  fsm_e                  fsm_q, fsm_d;
  logic [VIDX_W-1:0]     vidx_q, vidx_d;
  logic [2:0]            vstate_q [NUM_VOICES];
  logic [2:0]            vstate_d [NUM_VOICES];
  logic [17:0]           vvol_q   [NUM_VOICES];
  logic [17:0]           vvol_d   [NUM_VOICES];
  logic [3:0]            chan_q   [NUM_VOICES];
  logic [3:0]            chan_d   [NUM_VOICES];
  logic [NUM_VOICES-1:0] pend_on_q, pend_on_d;
  logic [NUM_VOICES-1:0] pend_off_q, pend_off_d;
  logic [2:0]            drv_state_q, drv_state_d;
  logic [17:0]           drv_vol_q, drv_vol_d;
  logic                  drv_pressed_q, drv_pressed_d;
  logic                  drv_released_q, drv_released_d;
  logic [3:0]            drv_chan_q, drv_chan_d;
  logic                  fifo_hold_q, fifo_hold_d;
  logic                  overrun_q, overrun_d;

  logic                  busy;
  logic                  skip;
  logic                  sweep_end;
  logic                  vol_valid;
  logic [17:0]           vol_value;

  // Next-state logic for the sweep FSM, voice registers and datapath drive.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    fsm_d          = fsm_q;
    vidx_d         = vidx_q;
    vstate_d       = vstate_q;
    vvol_d         = vvol_q;
    chan_d         = chan_q;
    pend_on_d      = pend_on_q;
    pend_off_d     = pend_off_q;
    drv_state_d    = drv_state_q;
    drv_vol_d      = drv_vol_q;
    drv_pressed_d  = drv_pressed_q;
    drv_released_d = drv_released_q;
    drv_chan_d     = drv_chan_q;
    overrun_d      = overrun_q;
    vol_valid      = 1'b0;
    vol_value      = '0;

    busy = (fsm_q != IDLE);
`ifdef ADSR_SKIP_BLANK_EN
    skip = (fsm_q == READ) && (drv_state_q == ST_BLANK) && !drv_pressed_q;
`else
    skip = 1'b0;
`endif
    sweep_end = (vidx_q == LAST) && ((fsm_q == WRITE) || skip);

    // Write-back of the datapath result and consumption of the pending flags.
    if (fsm_q == WRITE) begin
      vstate_d[vidx_q]   = bus.i_adsr_state;
      vvol_d[vidx_q]     = bus.i_adsr_volume;
      pend_on_d[vidx_q]  = 1'b0;
      pend_off_d[vidx_q] = 1'b0;
      vol_valid          = 1'b1;
      vol_value          = bus.i_adsr_volume;
    end
    if (skip) begin
      pend_off_d[vidx_q] = 1'b0;
      vol_valid          = 1'b1;
    end

    // Event capture comes after the clears so a same-cycle event survives.
    if (bus.i_ev_valid) begin
      if (bus.i_ev_on) begin
        pend_on_d[bus.i_ev_voice] = 1'b1;
        chan_d[bus.i_ev_voice]    = bus.i_ev_channel;
      end else begin
        pend_off_d[bus.i_ev_voice] = 1'b1;
      end
    end

    unique case (fsm_q)
      IDLE: begin
        if (bus.i_tick) begin
          fsm_d  = READ;
          vidx_d = '0;
        end
      end
      READ: begin
        if (!skip) begin
          fsm_d = WRITE;
        end else if (vidx_q == LAST) begin
          fsm_d = IDLE;
        end else begin
          vidx_d = vidx_q + VIDX_W'(1);
        end
      end
      WRITE: begin
        if (vidx_q == LAST) begin
          fsm_d = IDLE;
        end else begin
          fsm_d  = READ;
          vidx_d = vidx_q + VIDX_W'(1);
        end
      end
      default: fsm_d = IDLE;
    endcase

    // A tick on the final cycle of a sweep chains straight into the next one.
    if (bus.i_tick && sweep_end) begin
      fsm_d  = READ;
      vidx_d = '0;
    end
    if (bus.i_tick && busy && !sweep_end) begin
      overrun_d = 1'b1;
    end

    // Datapath drive is loaded on entry to READ and held through WRITE/IDLE.
    if (fsm_d == READ) begin
      drv_state_d    = vstate_d[vidx_d];
      drv_vol_d      = vvol_d[vidx_d];
      drv_pressed_d  = pend_on_d[vidx_d];
      drv_released_d = pend_off_d[vidx_d];
      drv_chan_d     = chan_d[vidx_d];
    end

    fifo_hold_d = busy ? ~bus.i_drum_busy[vidx_q] : fifo_hold_q;
  end

  // State registers with synchronous active-high reset; reset aborts any sweep.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fsm_q          <= IDLE;
      vidx_q         <= '0;
      // NOTE: the per-voice arrays are reset explicitly because every voice must start BLANK and silent.
      for (int i = 0; i < NUM_VOICES; i++) begin
        vstate_q[i] <= ST_BLANK;
        vvol_q[i]   <= '0;
        chan_q[i]   <= '0;
      end
      pend_on_q      <= '0;
      pend_off_q     <= '0;
      drv_state_q    <= '0;
      drv_vol_q      <= '0;
      drv_pressed_q  <= 1'b0;
      drv_released_q <= 1'b0;
      drv_chan_q     <= '0;
      fifo_hold_q    <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      fsm_q          <= fsm_d;
      vidx_q         <= vidx_d;
      vstate_q       <= vstate_d;
      vvol_q         <= vvol_d;
      chan_q         <= chan_d;
      pend_on_q      <= pend_on_d;
      pend_off_q     <= pend_off_d;
      drv_state_q    <= drv_state_d;
      drv_vol_q      <= drv_vol_d;
      drv_pressed_q  <= drv_pressed_d;
      drv_released_q <= drv_released_d;
      drv_chan_q     <= drv_chan_d;
      fifo_hold_q    <= fifo_hold_d;
      overrun_q      <= overrun_d;
    end
  end

  assign bus.o_ev_ready           = 1'b1;
  assign bus.o_adsr_state         = drv_state_q;
  assign bus.o_adsr_volume        = drv_vol_q;
  assign bus.o_adsr_note_pressed  = drv_pressed_q;
  assign bus.o_adsr_note_released = drv_released_q;
  assign bus.o_adsr_channel       = drv_chan_q;
  assign bus.o_adsr_fifo_empty    = busy ? ~bus.i_drum_busy[vidx_q] : fifo_hold_q;
  assign bus.o_vol_valid          = vol_valid;
  assign bus.o_vol_voice          = vol_valid ? vidx_q : '0;
  assign bus.o_vol_value          = vol_value;
  assign bus.o_busy               = busy;
  assign bus.o_overrun            = overrun_q;

endmodule

// File: tb/tb_adsr_voice_sched.sv
// Testbench for adsr_voice_sched: table of per-sweep vectors against a stub
// datapath plus hand sequences for overrun, chained ticks, same-cycle events,
// mid-sweep reset and (when ADSR_SKIP_BLANK_EN is defined) blank skipping.
module tb_adsr_voice_sched;

  localparam int NV = 16;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;

  adsr_voice_sched_if #(.NUM_VOICES(NV), .VIDX_W(4)) bus ();

  adsr_voice_sched #(.NUM_VOICES(NV), .VIDX_W(4)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  // Stub datapath: a press moves to ATTACK, a release to RELEASE; any
  // non-blank voice gains 1000 volume per update.
  always_comb begin
    bus.i_adsr_state  = bus.o_adsr_note_pressed  ? 3'd1 :
                        bus.o_adsr_note_released ? 3'd4 : bus.o_adsr_state;
    bus.i_adsr_volume = (bus.o_adsr_state == 3'd0) ? 18'd0 : bus.o_adsr_volume + 18'd1000;
  end

  typedef struct packed {
    logic [2:0]  st;
    logic [17:0] vol;
    logic        p;
    logic        r;
    logic [3:0]  ch;
    logic        e;
    logic [17:0] strobe;
  } cap_t;

  typedef struct {
    logic        ev_valid;
    logic        ev_on;
    logic [3:0]  voice;
    logic [3:0]  chan;
    logic        drum;
    cap_t        exp;
  } vec_t;

  int          n_vec = 0;
  int          n_bad = 0;
  int          busy_cnt = 0;
  int          cap_cnt = 0;
  cap_t        cap;
  logic [3:0]  watch_voice = 4'd0;
  logic [3:0]  q_voice[$];
  logic [17:0] q_val[$];
  vec_t        vecs[9];
  vec_t        cur;

  // Monitor sampled on the falling edge, away from the active edge.
  always @(negedge i_clk) begin
    if (bus.o_busy) busy_cnt <= busy_cnt + 1;
    if (bus.o_vol_valid) begin
      q_voice.push_back(bus.o_vol_voice);
      q_val.push_back(bus.o_vol_value);
      if (bus.o_vol_voice == watch_voice) begin
        cap     <= '{bus.o_adsr_state, bus.o_adsr_volume, bus.o_adsr_note_pressed,
                     bus.o_adsr_note_released, bus.o_adsr_channel, bus.o_adsr_fifo_empty,
                     bus.o_vol_value};
        cap_cnt <= cap_cnt + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic pulse_tick();
    bus.i_tick = 1'b1;
    step(1);
    bus.i_tick = 1'b0;
  endtask

  task automatic send_ev(input logic on, input logic [3:0] v, input logic [3:0] ch);
    bus.i_ev_valid   = 1'b1;
    bus.i_ev_on      = on;
    bus.i_ev_voice   = v;
    bus.i_ev_channel = ch;
    step(1);
    bus.i_ev_valid   = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.o_busy && n < 300) begin
      step(1);
      n++;
    end
    if (bus.o_busy) check("sweep_timeout", 32'(bus.o_busy), 32'd0);
  endtask

  task automatic wait_strobe(input logic [3:0] v);
    int n = 0;
    while (!(bus.o_vol_valid && bus.o_vol_voice == v) && n < 300) begin
      step(1);
      n++;
    end
    check($sformatf("reach_voice%0d", v), 32'({bus.o_vol_valid, bus.o_vol_voice}), 32'({1'b1, v}));
  endtask

  function automatic int exp_len(input int active);
`ifdef ADSR_SKIP_BLANK_EN
    return NV + active;
`else
    return 2 * NV + 0 * active;
`endif
  endfunction

  initial begin
    int b0, s0, c0;

    //                ev  on  voice  chan  drum   st    vol      p  r  ch     e  strobe
    vecs[0] = '{1'b0, 1'b0, 4'd0, 4'd0, 1'b1, '{3'd0, 18'd0,    1'b0, 1'b0, 4'd0,  1'b0, 18'd0}};
    vecs[1] = '{1'b1, 1'b1, 4'd3, 4'd0, 1'b1, '{3'd0, 18'd0,    1'b1, 1'b0, 4'd0,  1'b0, 18'd0}};
    vecs[2] = '{1'b0, 1'b0, 4'd3, 4'd0, 1'b1, '{3'd1, 18'd0,    1'b0, 1'b0, 4'd0,  1'b0, 18'd1000}};
    vecs[3] = '{1'b0, 1'b0, 4'd3, 4'd0, 1'b1, '{3'd1, 18'd1000, 1'b0, 1'b0, 4'd0,  1'b0, 18'd2000}};
    vecs[4] = '{1'b1, 1'b1, 4'd5, 4'd9, 1'b0, '{3'd0, 18'd0,    1'b1, 1'b0, 4'd9,  1'b1, 18'd0}};
    vecs[5] = '{1'b1, 1'b0, 4'd5, 4'd0, 1'b0, '{3'd1, 18'd0,    1'b0, 1'b1, 4'd9,  1'b1, 18'd1000}};
    vecs[6] = '{1'b0, 1'b0, 4'd5, 4'd0, 1'b1, '{3'd4, 18'd1000, 1'b0, 1'b0, 4'd9,  1'b0, 18'd2000}};
    vecs[7] = '{1'b1, 1'b0, 4'd3, 4'd0, 1'b1, '{3'd1, 18'd5000, 1'b0, 1'b1, 4'd0,  1'b0, 18'd6000}};
    vecs[8] = '{1'b1, 1'b1, 4'd5, 4'd12, 1'b1, '{3'd4, 18'd3000, 1'b1, 1'b0, 4'd12, 1'b0, 18'd4000}};

    bus.i_tick       = 1'b0;
    bus.i_ev_valid   = 1'b0;
    bus.i_ev_on      = 1'b0;
    bus.i_ev_voice   = '0;
    bus.i_ev_channel = '0;
    bus.i_drum_busy  = '1;

    // Reset state.
    step(3);
    i_rst = 1'b0;
    check("rst_vol_valid", 32'(bus.o_vol_valid), 32'd0);
    check("rst_vol_voice", 32'(bus.o_vol_voice), 32'd0);
    check("rst_vol_value", 32'(bus.o_vol_value), 32'd0);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_overrun", 32'(bus.o_overrun), 32'd0);
    check("rst_drive", 32'({bus.o_adsr_state, bus.o_adsr_volume, bus.o_adsr_note_pressed,
                            bus.o_adsr_note_released, bus.o_adsr_channel, bus.o_adsr_fifo_empty}), 32'd0);
    check("ev_ready", 32'(bus.o_ev_ready), 32'd1);

    // First sweep after reset: latency, order, values and length.
    b0 = busy_cnt;
    s0 = q_voice.size();
    pulse_tick();
    check("lat_cycle1_valid", 32'(bus.o_vol_valid), 32'd0);
    check("lat_cycle1_busy", 32'(bus.o_busy), 32'd1);
    step(1);
    check("lat_cycle2_valid", 32'({bus.o_vol_valid, bus.o_vol_voice}), 32'({1'b1, 4'd0}));
    wait_idle();
    check("sweep0_strobes", 32'(q_voice.size() - s0), 32'(NV));
    check("sweep0_len", 32'(busy_cnt - b0), 32'(exp_len(0)));
    for (int i = 0; i < NV; i++) begin
      if (s0 + i < q_voice.size()) begin
        check($sformatf("sweep0_order%0d", i), 32'(q_voice[s0 + i]), 32'(i));
        check($sformatf("sweep0_value%0d", i), 32'(q_val[s0 + i]), 32'd0);
      end
    end

    // Table-driven per-sweep vectors against the stub datapath.
    for (int k = 0; k < 9; k++) begin
      cur = vecs[k];
      watch_voice = cur.voice;
      bus.i_drum_busy = '1;
      bus.i_drum_busy[cur.voice] = cur.drum;
      if (cur.ev_valid) send_ev(cur.ev_on, cur.voice, cur.chan);
      c0 = cap_cnt;
      s0 = q_voice.size();
      pulse_tick();
      wait_idle();
      step(1);
      check($sformatf("v%0d_seen", k), 32'(cap_cnt - c0), 32'd1);
      check($sformatf("v%0d_strobes", k), 32'(q_voice.size() - s0), 32'(NV));
      check($sformatf("v%0d_state", k), 32'(cap.st), 32'(cur.exp.st));
      check($sformatf("v%0d_volume", k), 32'(cap.vol), 32'(cur.exp.vol));
      check($sformatf("v%0d_pressed", k), 32'(cap.p), 32'(cur.exp.p));
      check($sformatf("v%0d_released", k), 32'(cap.r), 32'(cur.exp.r));
      check($sformatf("v%0d_channel", k), 32'(cap.ch), 32'(cur.exp.ch));
      check($sformatf("v%0d_fifo_empty", k), 32'(cap.e), 32'(cur.exp.e));
      check($sformatf("v%0d_strobe", k), 32'(cap.strobe), 32'(cur.exp.strobe));
    end
    bus.i_drum_busy = '1;

    // Note-off landing in voice 3's WRITE cycle survives to the next sweep.
    watch_voice = 4'd3;
    pulse_tick();
    wait_strobe(4'd3);
    send_ev(1'b0, 4'd3, 4'd0);
    wait_idle();
    c0 = cap_cnt;
    pulse_tick();
    wait_idle();
    step(1);
    check("same_cycle_off_seen", 32'(cap_cnt - c0), 32'd1);
    check("same_cycle_off_released", 32'(cap.r), 32'd1);

    // Tick on the last strobe cycle chains a new sweep without overrun.
    b0 = busy_cnt;
    s0 = q_voice.size();
    pulse_tick();
    wait_strobe(4'd15);
    bus.i_tick = 1'b1;
    step(1);
    bus.i_tick = 1'b0;
    check("chain_busy", 32'(bus.o_busy), 32'd1);
    check("chain_no_overrun", 32'(bus.o_overrun), 32'd0);
    wait_idle();
    check("chain_strobes", 32'(q_voice.size() - s0), 32'(2 * NV));
    check("chain_len", 32'(busy_cnt - b0), 32'(2 * exp_len(2)));

    // Tick at cycle 10 of a sweep: sticky overrun, tick dropped.
    b0 = busy_cnt;
    s0 = q_voice.size();
    pulse_tick();
    step(9);
    bus.i_tick = 1'b1;
    step(1);
    bus.i_tick = 1'b0;
    check("overrun_set", 32'(bus.o_overrun), 32'd1);
    wait_idle();
    check("overrun_strobes", 32'(q_voice.size() - s0), 32'(NV));
    check("overrun_len", 32'(busy_cnt - b0), 32'(exp_len(2)));
    step(5);
    check("overrun_no_resweep", 32'(busy_cnt - b0), 32'(exp_len(2)));
    check("overrun_sticky", 32'(bus.o_overrun), 32'd1);

    // Reset in voice 3's WRITE cycle aborts the sweep and the write-back.
    pulse_tick();
    wait_strobe(4'd3);
    i_rst = 1'b1;
    step(1);
    i_rst = 1'b0;
    check("midrst_busy", 32'(bus.o_busy), 32'd0);
    check("midrst_overrun", 32'(bus.o_overrun), 32'd0);
    check("midrst_state", 32'(bus.o_adsr_state), 32'd0);
    watch_voice = 4'd3;
    c0 = cap_cnt;
    s0 = q_voice.size();
    pulse_tick();
    wait_idle();
    step(1);
    check("midrst_v3_seen", 32'(cap_cnt - c0), 32'd1);
    check("midrst_v3_state", 32'(cap.st), 32'd0);
    check("midrst_v3_volume", 32'(cap.vol), 32'd0);
    check("midrst_strobes", 32'(q_voice.size() - s0), 32'(NV));

    // Only voice 2 active: sweep length and per-voice values.
    send_ev(1'b1, 4'd2, 4'd1);
    b0 = busy_cnt;
    pulse_tick();
    wait_idle();
    check("v2_press_len", 32'(busy_cnt - b0), 32'(exp_len(1)));
    b0 = busy_cnt;
    s0 = q_voice.size();
    pulse_tick();
    wait_idle();
    check("v2_len", 32'(busy_cnt - b0), 32'(exp_len(1)));
    check("v2_strobes", 32'(q_voice.size() - s0), 32'(NV));
    for (int i = 0; i < NV; i++) begin
      if (s0 + i < q_voice.size()) begin
        check($sformatf("v2_sweep_value%0d", i), 32'(q_val[s0 + i]),
              (q_voice[s0 + i] == 4'd2) ? 32'd1000 : 32'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
